// File: rtl/alu_seq.sv
// alu_seq: parametrised accumulator ALU with carry-chained ADC/SBC, a
// multi-cycle shift/rotate (1..8 bits) with busy/done handshake, and a
// tri-state data-bus interface driven from the output latch.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       instruction,
  input  logic             ldAcc,
  input  logic             useAlu,
  input  logic             dbusSelect,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] latch,
  output logic             c,
  output logic             z,
  output logic             busy,
  output logic             done,
  inout  wire  [WIDTH-1:0] d_bus
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_NAND  = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b011;
  localparam logic [2:0] OP_ADC   = 3'b100;
  localparam logic [2:0] OP_ST    = 3'b101;
  localparam logic [2:0] OP_SBC   = 3'b110;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_acc, w_acc_next;
  logic [WIDTH-1:0] r_latch, w_latch_next;
  logic             r_c, w_c_next;
  logic             r_z, w_z_next;
  logic             r_done, w_done_next;
  logic             r_dir, w_dir_next;
  logic             r_rot, w_rot_next;
  logic [3:0]       r_cnt, w_cnt_next;

  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_opnd;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_nand;
  logic [WIDTH-1:0] w_shifted;
  logic             w_shift_out;

  assign w_op   = instruction[7:5];
  assign w_nand = ~(r_acc & d_bus);

  // Adder operand/carry-in selection: subtraction adds the complement, and the
  // carry-chained forms feed the stored carry flag in.
  always_comb begin
    w_opnd = d_bus;
    w_cin  = 1'b0;
    case (w_op)
      OP_SUB: begin
        w_opnd = ~d_bus;
        w_cin  = 1'b1;
      end
      OP_ADC: w_cin = r_c;
      OP_SBC: begin
        w_opnd = ~d_bus;
        w_cin  = r_c;
      end
      default: ;
    endcase
    w_sum = {1'b0, r_acc} + {1'b0, w_opnd} + {{WIDTH{1'b0}}, w_cin};
  end

  // One-bit shift step using the direction/mode captured when the shift was accepted.
  always_comb begin
    if (r_dir) begin
      w_shifted   = {r_rot & r_acc[0], r_acc[WIDTH-1:1]};
      w_shift_out = r_acc[0];
    end else begin
      w_shifted   = {r_acc[WIDTH-2:0], r_rot & r_acc[WIDTH-1]};
      w_shift_out = r_acc[WIDTH-1];
    end
  end

  // Next-state and datapath update: idle accepts a load or an op, shifting
  // steps the accumulator until the captured count runs out.
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_latch_next = r_latch;
    w_c_next     = r_c;
    w_z_next     = r_z;
    w_done_next  = 1'b0;
    w_dir_next   = r_dir;
    w_rot_next   = r_rot;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (ldAcc) begin
          w_acc_next = d_bus;
        end else if (useAlu) begin
          case (w_op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
              w_acc_next   = w_sum[WIDTH-1:0];
              w_latch_next = w_sum[WIDTH-1:0];
              w_c_next     = w_sum[WIDTH];
              w_z_next     = (w_sum[WIDTH-1:0] == '0);
              w_done_next  = 1'b1;
            end
            OP_NAND: begin
              w_acc_next   = w_nand;
              w_latch_next = w_nand;
              w_z_next     = (w_nand == '0);
              w_done_next  = 1'b1;
            end
            OP_SHIFT: begin
              w_state_next = S_SHIFT;
              w_dir_next   = instruction[4];
              w_rot_next   = instruction[3];
              w_cnt_next   = {1'b0, instruction[2:0]} + 4'd1;
            end
            OP_ST: begin
              w_latch_next = r_acc;
              w_done_next  = 1'b1;
            end
            default: w_done_next = 1'b1;
          endcase
        end
      end
      S_SHIFT: begin
        w_acc_next = w_shifted;
        w_c_next   = w_shift_out;
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_latch_next = w_shifted;
          w_z_next     = (w_shifted == '0);
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Datapath registers; reset clears everything, including a shift in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_latch <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_done  <= 1'b0;
      r_dir   <= 1'b0;
      r_rot   <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      r_acc   <= w_acc_next;
      r_latch <= w_latch_next;
      r_c     <= w_c_next;
      r_z     <= w_z_next;
      r_done  <= w_done_next;
      r_dir   <= w_dir_next;
      r_rot   <= w_rot_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign acc   = r_acc;
  assign latch = r_latch;
  assign c     = r_c;
  assign z     = r_z;
  assign busy  = (r_state == S_SHIFT);
  assign done  = r_done;
  assign d_bus = dbusSelect ? r_latch : {WIDTH{1'bz}};

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised successor of the CPU's 8-bit accumulator ALU. It keeps the accumulator, the output latch, the C/Z flags and the tri-state data-bus interface, and adds three things: width is a parameter, there are carry-chained ADC/SBC operations, and there is a multi-cycle shift/rotate by 1–8 bits with a `busy`/`done` handshake. It sits on the CPU's bidirectional data bus between the sequencer (control strobes) and memory/registers.

## Interface
- `WIDTH`, 8, datapath width (accumulator, latch, d_bus); legal 4..32
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `instruction` in 8: [7:5] opcode, [4:0] modifiers
- `ldAcc` in 1: load acc from d_bus this edge
- `useAlu` in 1: execute opcode with d_bus as operand
- `dbusSelect` in 1: drive latch onto d_bus
- `acc` out WIDTH: accumulator
- `latch` out WIDTH: result/store latch
- `c` out 1: carry flag
- `z` out 1: zero flag
- `busy` out 1: shift in progress
- `done` out 1: one-cycle pulse when an op completes
- `d_bus` inout WIDTH: driven with `latch` when `dbusSelect`=1, else high-Z

## Operation
- Opcodes, with B = d_bus and all arithmetic mod 2^WIDTH:
  - 000 ADD: acc+B
  - 001 SUB: acc+~B+1
  - 010 NAND: ~(acc&B)
  - 011 SHIFT: see below
  - 100 ADC: acc+B+c
  - 101 ST: latch<=acc; flags unchanged
  - 110 SBC: acc+~B+c
  - 111: no operation; `done` still pulses
- ADD/SUB/ADC/SBC: `c` = carry out of bit WIDTH-1. For SUB/SBC, c=1 means no borrow.
- NAND: `c` is unchanged.
- Every result op writes the result to both `acc` and `latch`. `z` = (result==0).
- SHIFT modifiers:
  - [4] direction: 0 = left, 1 = right
  - [3] mode: 0 = logical (zero fill), 1 = rotate (the bit shifted out re-enters at the other end)
  - [2:0] N-1, so N is 1..8; N may exceed WIDTH and wraps naturally
- SHIFT ignores d_bus. Each cycle `c` takes the bit shifted out.
- `ldAcc`: acc<=d_bus. Flags and latch are unchanged; `done` does not pulse.
- Priority when idle: `ldAcc` over `useAlu`. If both are 1, only the load occurs.
- While `busy`=1: `ldAcc`, `useAlu` and `instruction` are ignored. Opcode, modifiers and count were captured at accept.
- `dbusSelect` is independent of busy. Driving d_bus externally while `dbusSelect`=1 is a system error; no check is made.
- States:
  - IDLE → SHIFTING when useAlu=1, opcode=011 and ldAcc=0
  - SHIFTING → IDLE when remaining count reaches 0
  - All other ops complete in IDLE in one edge.

## Timing
- Reset values: acc=0, latch=0, c=0, z=0, busy=0, done=0, state IDLE, d_bus high-Z unless `dbusSelect`=1 (then it drives 0).
- Single-cycle ops: accepted at edge k. Results and flags are valid after edge k; `done`=1 for the cycle after edge k.
- SHIFT accepted at edge k:
  - `busy`=1 after edge k.
  - acc shifts one bit at each of edges k+1..k+N, with intermediate acc values visible.
  - At edge k+N: latch<=acc result, z updated, busy<=0, done<=1 for one cycle.
  - A new op may be accepted at edge k+N+1. Total latency is N+1 edges.
- `reset` asserted mid-shift: immediate abort to reset values; no `done`.
- d_bus drive/release follows `dbusSelect` combinationally.

## Test plan
- WIDTH=8 reset, then LD 0x9E, then ADD d_bus=0x61 → acc=latch=0xFF, c=0, z=0, done pulses once.
- Continue: SUB 0xFF → acc=0x00, c=1, z=1. Then NAND 0xAA → acc=0xFF, c=1 held, z=0. Then ST → latch=0xFF; dbusSelect=1 → d_bus=0xFF; dbusSelect=0 → d_bus high-Z.
- acc=0x81, SHIFT instruction=0x62 (left, logical, N=3) → busy high 3 cycles, acc 0x02/0x04/0x08, final c=0, latch=0x08, done one cycle after the third shift. Then instruction=0x78 (right, rotate, N=1) on acc=0x01 → acc=0x80, c=1.
- ldAcc and useAlu together (ADD, d_bus=0x05, acc=0x10) → acc=0x05, flags unchanged, no done. During a busy shift, apply ldAcc/useAlu/new instruction → all ignored; result matches the undisturbed shift.
- Start SHIFT N=8, assert reset after 4 shift edges → all outputs at reset values at once, busy=0, no done pulse.
- WIDTH=16: LD 0xFFFF; ADD 0x0001 → 0x0000, c=1, z=1. Then ADC 0x0000 → 0x0001, c=0, z=0. Then SBC 0x0001 with c=0 → 0xFFFF, c=0 (borrow).
